// File: rtl/gpio_shift_out_if.sv
// Parallel-load / serial-out GPIO bus: upstream word and handshake plus the three
// shift-register pins. The master drives data_in/start, the slave (the shifter) drives the rest.
interface gpio_shift_out_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] data_in;
   logic             start;
   logic             busy;
   logic             done;
   logic             ser_data;
   logic             ser_clk;
   logic             ser_latch;

   modport master (
      output data_in, start,
      input  busy, done, ser_data, ser_clk, ser_latch
   );

   modport slave (
      input  data_in, start,
      output busy, done, ser_data, ser_clk, ser_latch
   );
endinterface

// File: rtl/gpio_shift_out.sv
// Serialises a WIDTH-bit word MSB-first onto an external shift register
// (data / shift clock / latch), each serial phase lasting CLK_DIV cycles.
module gpio_shift_out #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned CLK_DIV = 25
) (
   input  logic            CLOCK_50,
   input  logic            resetn,
   gpio_shift_out_if.slave bus
);

   localparam int unsigned BIT_W = $clog2(WIDTH);
   localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOW   = 2'd1,
      HIGH  = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   shreg_q,     shreg_d;
   logic [BIT_W-1:0]   bit_q,       bit_d;
   logic [PH_W-1:0]    ph_q,        ph_d;
   logic               ser_data_q,  ser_data_d;
   logic               ser_clk_q,   ser_clk_d;
   logic               ser_latch_q, ser_latch_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               phase_end;

   assign phase_end = (ph_q == PH_LAST);

   // State and all registered outputs; reset abandons any transfer in flight.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         bit_q       <= '0;
         ph_q        <= '0;
         ser_data_q  <= 1'b0;
         ser_clk_q   <= 1'b0;
         ser_latch_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         ph_q        <= ph_d;
         ser_data_q  <= ser_data_d;
         ser_clk_q   <= ser_clk_d;
         ser_latch_q <= ser_latch_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state; ser_data only moves together with a falling (or idle) ser_clk.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_d       = bit_q;
      ph_d        = ph_q;
      ser_data_d  = ser_data_q;
      ser_clk_d   = ser_clk_q;
      ser_latch_d = ser_latch_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shreg_d    = bus.data_in;
               bit_d      = BIT_LAST;
               ph_d       = '0;
               ser_data_d = bus.data_in[WIDTH-1];
               ser_clk_d  = 1'b0;
               busy_d     = 1'b1;
               state_d    = LOW;
            end
         end

         LOW: begin
            if (phase_end) begin
               ph_d      = '0;
               ser_clk_d = 1'b1;
               state_d   = HIGH;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end

         HIGH: begin
            if (phase_end) begin
               ph_d      = '0;
               ser_clk_d = 1'b0;
               if (bit_q != '0) begin
                  shreg_d    = shreg_q << 1;
                  ser_data_d = shreg_q[WIDTH-2];
                  bit_d      = bit_q - BIT_W'(1);
                  state_d    = LOW;
               end else begin
                  ser_latch_d = 1'b1;
                  ser_data_d  = 1'b0;
                  state_d     = LATCH;
               end
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end

         LATCH: begin
            if (phase_end) begin
               ph_d        = '0;
               ser_latch_d = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.ser_data  = ser_data_q;
   assign bus.ser_clk   = ser_clk_q;
   assign bus.ser_latch = ser_latch_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
